// File: rtl/rv32i_rs_ooo.sv
// Out-of-order reservation station: collapsing age queue with multi-port wakeup
// and oldest-ready select feeding a single processing unit.
module rv32i_rs_ooo #(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter int unsigned NUM_WB      = 2,
    parameter int unsigned DATA_BW     = 32,
    parameter int unsigned TAG_BW      = 6,
    parameter int unsigned ROB_IDX_BW  = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_push,
    input  logic                            i_src1_value_vld,
    input  logic                            i_src2_value_vld,
    input  logic [DATA_BW-1:0]              i_src1_value,
    input  logic [DATA_BW-1:0]              i_src2_value,
    input  logic [TAG_BW-1:0]               i_src1_phys_rf_tag,
    input  logic [TAG_BW-1:0]               i_src2_phys_rf_tag,
    input  logic [TAG_BW-1:0]               i_dst_phys_rf_tag,
    input  logic [ROB_IDX_BW-1:0]           i_rob_entry_idx,
    input  logic [NUM_WB-1:0]               i_write_back,
    input  logic [NUM_WB*TAG_BW-1:0]        i_phys_rf_wr_idx,
    input  logic [NUM_WB*DATA_BW-1:0]       i_wdata,
    input  logic                            i_flush,
    input  logic                            i_pu_rdy,
    output logic                            o_full,
    output logic                            o_empty,
    output logic [$clog2(NUM_ENTRIES+1)-1:0] o_count,
    output logic                            o_vld,
    output logic [DATA_BW-1:0]              o_src1_value,
    output logic [DATA_BW-1:0]              o_src2_value,
    output logic [TAG_BW-1:0]               o_dst_phys_rf_tag,
    output logic [ROB_IDX_BW-1:0]           o_rob_entry_idx
);

    localparam int unsigned CNT_BW = $clog2(NUM_ENTRIES + 1);
    localparam int unsigned IDX_BW = $clog2(NUM_ENTRIES);

    // Slot storage, slot 0 oldest; valid slots are 0..count_q-1
    logic [CNT_BW-1:0]                          count_q, count_d;
    logic [NUM_ENTRIES-1:0]                     s1_rdy_q, s1_rdy_d, s2_rdy_q, s2_rdy_d;
    logic [NUM_ENTRIES-1:0][DATA_BW-1:0]        s1_data_q, s1_data_d, s2_data_q, s2_data_d;
    logic [NUM_ENTRIES-1:0][TAG_BW-1:0]         s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
    logic [NUM_ENTRIES-1:0][TAG_BW-1:0]         dst_q, dst_d;
    logic [NUM_ENTRIES-1:0][ROB_IDX_BW-1:0]     rob_q, rob_d;

    logic                 sel_found;
    logic [IDX_BW-1:0]    sel_idx;
    logic                 issue_fire;
    logic                 push_ok;
    logic [CNT_BW-1:0]    base;
    logic                 wk_hit;
    logic [DATA_BW-1:0]   wk_data;

    // Lowest-numbered write-back port whose tag matches wins
    function automatic void wb_lookup(
        input  logic [TAG_BW-1:0]          tag,
        input  logic [NUM_WB-1:0]          wb,
        input  logic [NUM_WB*TAG_BW-1:0]   wb_tag,
        input  logic [NUM_WB*DATA_BW-1:0]  wb_data,
        output logic                       hit,
        output logic [DATA_BW-1:0]         data
    );
        hit  = 1'b0;
        data = '0;
        for (int p = int'(NUM_WB) - 1; p >= 0; p--) begin
            if (wb[p] && (wb_tag[p*TAG_BW +: TAG_BW] == tag)) begin
                hit  = 1'b1;
                data = wb_data[p*DATA_BW +: DATA_BW];
            end
        end
    endfunction

    // Oldest valid slot with both operands ready
    always_comb begin : select_oldest
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
            if ((CNT_BW'(i) < count_q) && s1_rdy_q[i] && s2_rdy_q[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_BW'(i);
            end
        end
    end

    assign issue_fire = sel_found && i_pu_rdy && !i_flush;
    assign push_ok    = i_push && !o_full && !i_flush;

    // Collapse on issue, wake stored operands, then append the pushed entry
    always_comb begin : next_state
        count_d   = count_q;
        s1_rdy_d  = s1_rdy_q;
        s2_rdy_d  = s2_rdy_q;
        s1_data_d = s1_data_q;
        s2_data_d = s2_data_q;
        s1_tag_d  = s1_tag_q;
        s2_tag_d  = s2_tag_q;
        dst_d     = dst_q;
        rob_d     = rob_q;
        base      = count_q;
        wk_hit    = 1'b0;
        wk_data   = '0;
        if (i_flush) begin
            count_d = '0;
        end else begin
            if (issue_fire) begin
                for (int i = 0; i < int'(NUM_ENTRIES) - 1; i++) begin
                    if (IDX_BW'(i) >= sel_idx) begin
                        s1_rdy_d[i]  = s1_rdy_q[i+1];
                        s2_rdy_d[i]  = s2_rdy_q[i+1];
                        s1_data_d[i] = s1_data_q[i+1];
                        s2_data_d[i] = s2_data_q[i+1];
                        s1_tag_d[i]  = s1_tag_q[i+1];
                        s2_tag_d[i]  = s2_tag_q[i+1];
                        dst_d[i]     = dst_q[i+1];
                        rob_d[i]     = rob_q[i+1];
                    end
                end
                s1_rdy_d[NUM_ENTRIES-1] = 1'b0;
                s2_rdy_d[NUM_ENTRIES-1] = 1'b0;
                base = count_q - CNT_BW'(1);
            end
            for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
                if (CNT_BW'(i) < base) begin
                    if (!s1_rdy_d[i]) begin
                        wb_lookup(s1_tag_d[i], i_write_back, i_phys_rf_wr_idx, i_wdata, wk_hit, wk_data);
                        if (wk_hit) begin
                            s1_rdy_d[i]  = 1'b1;
                            s1_data_d[i] = wk_data;
                        end
                    end
                    if (!s2_rdy_d[i]) begin
                        wb_lookup(s2_tag_d[i], i_write_back, i_phys_rf_wr_idx, i_wdata, wk_hit, wk_data);
                        if (wk_hit) begin
                            s2_rdy_d[i]  = 1'b1;
                            s2_data_d[i] = wk_data;
                        end
                    end
                end
            end
            if (push_ok) begin
                for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
                    if (CNT_BW'(i) == base) begin
                        s1_rdy_d[i]  = i_src1_value_vld;
                        s2_rdy_d[i]  = i_src2_value_vld;
                        s1_data_d[i] = i_src1_value_vld ? i_src1_value : '0;
                        s2_data_d[i] = i_src2_value_vld ? i_src2_value : '0;
                        s1_tag_d[i]  = i_src1_phys_rf_tag;
                        s2_tag_d[i]  = i_src2_phys_rf_tag;
                        dst_d[i]     = i_dst_phys_rf_tag;
                        rob_d[i]     = i_rob_entry_idx;
                        if (!i_src1_value_vld) begin
                            wb_lookup(i_src1_phys_rf_tag, i_write_back, i_phys_rf_wr_idx, i_wdata, wk_hit, wk_data);
                            if (wk_hit) begin
                                s1_rdy_d[i]  = 1'b1;
                                s1_data_d[i] = wk_data;
                            end
                        end
                        if (!i_src2_value_vld) begin
                            wb_lookup(i_src2_phys_rf_tag, i_write_back, i_phys_rf_wr_idx, i_wdata, wk_hit, wk_data);
                            if (wk_hit) begin
                                s2_rdy_d[i]  = 1'b1;
                                s2_data_d[i] = wk_data;
                            end
                        end
                    end
                end
            end
            count_d = base + CNT_BW'(push_ok);
        end
    end

    // State register with synchronous reset clearing every field
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            s1_rdy_q  <= '0;
            s2_rdy_q  <= '0;
            s1_data_q <= '0;
            s2_data_q <= '0;
            s1_tag_q  <= '0;
            s2_tag_q  <= '0;
            dst_q     <= '0;
            rob_q     <= '0;
        end else begin
            count_q   <= count_d;
            s1_rdy_q  <= s1_rdy_d;
            s2_rdy_q  <= s2_rdy_d;
            s1_data_q <= s1_data_d;
            s2_data_q <= s2_data_d;
            s1_tag_q  <= s1_tag_d;
            s2_tag_q  <= s2_tag_d;
            dst_q     <= dst_d;
            rob_q     <= rob_d;
        end
    end

    assign o_count           = count_q;
    assign o_full            = (count_q == CNT_BW'(NUM_ENTRIES));
    assign o_empty           = (count_q == '0);
    assign o_vld             = sel_found;
    assign o_src1_value      = s1_data_q[sel_idx];
    assign o_src2_value      = s2_data_q[sel_idx];
    assign o_dst_phys_rf_tag = dst_q[sel_idx];
    assign o_rob_entry_idx   = rob_q[sel_idx];

endmodule

// File: tb/tb_rv32i_rs_ooo.sv
// Self-checking bench for rv32i_rs_ooo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_rv32i_rs_ooo;

    localparam int NE = 4;
    localparam int NW = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_push, i_src1_value_vld, i_src2_value_vld;
    logic [31:0] i_src1_value, i_src2_value;
    logic [5:0]  i_src1_phys_rf_tag, i_src2_phys_rf_tag, i_dst_phys_rf_tag;
    logic [4:0]  i_rob_entry_idx;
    logic [1:0]  i_write_back;
    logic [11:0] i_phys_rf_wr_idx;
    logic [63:0] i_wdata;
    logic        i_flush, i_pu_rdy;
    logic        o_full, o_empty, o_vld;
    logic [2:0]  o_count;
    logic [31:0] o_src1_value, o_src2_value;
    logic [5:0]  o_dst_phys_rf_tag;
    logic [4:0]  o_rob_entry_idx;

    rv32i_rs_ooo dut (
        .clk(clk), .rst(rst), .i_push(i_push),
        .i_src1_value_vld(i_src1_value_vld), .i_src2_value_vld(i_src2_value_vld),
        .i_src1_value(i_src1_value), .i_src2_value(i_src2_value),
        .i_src1_phys_rf_tag(i_src1_phys_rf_tag), .i_src2_phys_rf_tag(i_src2_phys_rf_tag),
        .i_dst_phys_rf_tag(i_dst_phys_rf_tag), .i_rob_entry_idx(i_rob_entry_idx),
        .i_write_back(i_write_back), .i_phys_rf_wr_idx(i_phys_rf_wr_idx), .i_wdata(i_wdata),
        .i_flush(i_flush), .i_pu_rdy(i_pu_rdy),
        .o_full(o_full), .o_empty(o_empty), .o_count(o_count), .o_vld(o_vld),
        .o_src1_value(o_src1_value), .o_src2_value(o_src2_value),
        .o_dst_phys_rf_tag(o_dst_phys_rf_tag), .o_rob_entry_idx(o_rob_entry_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          r1;
        logic [31:0] v1;
        logic [5:0]  t1;
        bit          r2;
        logic [31:0] v2;
        logic [5:0]  t2;
        logic [5:0]  dst;
        logic [4:0]  rob;
    } ent_t;

    ent_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clr_in();
        i_push = 0; i_src1_value_vld = 0; i_src2_value_vld = 0;
        i_src1_value = '0; i_src2_value = '0;
        i_src1_phys_rf_tag = '0; i_src2_phys_rf_tag = '0;
        i_dst_phys_rf_tag = '0; i_rob_entry_idx = '0;
        i_write_back = '0; i_phys_rf_wr_idx = '0; i_wdata = '0;
        i_flush = 0; i_pu_rdy = 0;
    endtask

    task automatic set_push(input bit v1, input logic [31:0] d1, input logic [5:0] t1,
                            input bit v2, input logic [31:0] d2, input logic [5:0] t2,
                            input logic [5:0] dst, input logic [4:0] rob);
        i_push = 1; i_src1_value_vld = v1; i_src1_value = d1; i_src1_phys_rf_tag = t1;
        i_src2_value_vld = v2; i_src2_value = d2; i_src2_phys_rf_tag = t2;
        i_dst_phys_rf_tag = dst; i_rob_entry_idx = rob;
    endtask

    task automatic set_wb(input int p, input logic [5:0] tag, input logic [31:0] data);
        i_write_back[p] = 1'b1;
        i_phys_rf_wr_idx[p*6 +: 6] = tag;
        i_wdata[p*32 +: 32] = data;
    endtask

    // Value delivered to a waiting tag this cycle: first matching port in port order
    task automatic wb_find(input logic [5:0] tag, output bit hit, output logic [31:0] data);
        hit = 0; data = '0;
        for (int p = 0; p < NW; p++) begin
            if (!hit && i_write_back[p] && i_phys_rf_wr_idx[p*6 +: 6] == tag) begin
                hit = 1; data = i_wdata[p*32 +: 32];
            end
        end
    endtask

    // Compare outputs against the model, clock once, then advance the model
    task automatic step();
        int   sel;
        bit   issue, pushed, h;
        logic [31:0] d;
        ent_t e;
        sel = -1;
        for (int i = 0; i < q.size(); i++)
            if (sel < 0 && q[i].r1 && q[i].r2) sel = i;
        chk("count", 64'(o_count), 64'(q.size()));
        chk("full",  64'(o_full),  64'(q.size() == NE));
        chk("empty", 64'(o_empty), 64'(q.size() == 0));
        chk("vld",   64'(o_vld),   64'(sel >= 0));
        if (sel >= 0) begin
            chk("src1", 64'(o_src1_value), 64'(q[sel].v1));
            chk("src2", 64'(o_src2_value), 64'(q[sel].v2));
            chk("dst",  64'(o_dst_phys_rf_tag), 64'(q[sel].dst));
            chk("rob",  64'(o_rob_entry_idx), 64'(q[sel].rob));
        end
        issue  = (sel >= 0) && i_pu_rdy && !i_flush;
        pushed = i_push && (q.size() < NE) && !i_flush;
        @(posedge clk);
        if (i_flush) begin
            q.delete();
        end else begin
            if (issue) q.delete(sel);
            for (int i = 0; i < q.size(); i++) begin
                e = q[i];
                if (!e.r1) begin wb_find(e.t1, h, d); if (h) begin e.r1 = 1; e.v1 = d; end end
                if (!e.r2) begin wb_find(e.t2, h, d); if (h) begin e.r2 = 1; e.v2 = d; end end
                q[i] = e;
            end
            if (pushed) begin
                e.r1 = i_src1_value_vld; e.v1 = i_src1_value; e.t1 = i_src1_phys_rf_tag;
                e.r2 = i_src2_value_vld; e.v2 = i_src2_value; e.t2 = i_src2_phys_rf_tag;
                e.dst = i_dst_phys_rf_tag; e.rob = i_rob_entry_idx;
                if (!e.r1) begin wb_find(e.t1, h, d); if (h) begin e.r1 = 1; e.v1 = d; end end
                if (!e.r2) begin wb_find(e.t2, h, d); if (h) begin e.r2 = 1; e.v2 = d; end end
                q.push_back(e);
            end
        end
        @(negedge clk);
        clr_in();
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1;
        @(posedge clk);
        q.delete();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_vld"},   64'(o_vld), 64'(0));
        chk({tag, "_full"},  64'(o_full), 64'(0));
        chk({tag, "_empty"}, 64'(o_empty), 64'(1));
        chk({tag, "_count"}, 64'(o_count), 64'(0));
        chk({tag, "_src1"},  64'(o_src1_value), 64'(0));
        chk({tag, "_src2"},  64'(o_src2_value), 64'(0));
        chk({tag, "_dst"},   64'(o_dst_phys_rf_tag), 64'(0));
        chk({tag, "_rob"},   64'(o_rob_entry_idx), 64'(0));
    endtask

    initial begin
        clr_in();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset();
        chk_reset_vals("rst0");

        // Ordering: single ready entry presents next cycle then drains
        set_push(1, 32'hbbbbaaaa, 0, 1, 32'hcacacaca, 0, 6'h0c, 5'd1); i_pu_rdy = 1; step();
        chk("A_vld", 64'(o_vld), 64'(1));
        chk("A_src1", 64'(o_src1_value), 64'hbbbbaaaa);
        chk("A_src2", 64'(o_src2_value), 64'hcacacaca);
        chk("A_dst", 64'(o_dst_phys_rf_tag), 64'h0c);
        i_pu_rdy = 1; step();
        chk("A_cnt0", 64'(o_count), 64'(0));

        // Out-of-order: younger ready C issues ahead of waiting B
        set_push(0, 0, 6'h00, 0, 0, 6'h00, 6'h0a, 5'd2); step();
        set_push(1, 32'h1, 0, 1, 32'h2, 0, 6'h0b, 5'd3); step();
        chk("C_first", 64'(o_dst_phys_rf_tag), 64'h0b);
        i_pu_rdy = 1; step();
        chk("B_wait", 64'(o_vld), 64'(0));
        set_wb(1, 6'h00, 32'hdaddad00); step();
        chk("B_dst", 64'(o_dst_phys_rf_tag), 64'h0a);
        chk("B_src1", 64'(o_src1_value), 64'hdaddad00);
        chk("B_src2", 64'(o_src2_value), 64'hdaddad00);
        i_pu_rdy = 1; step();

        // Push bypass from a same-cycle write-back
        set_push(1, 32'h5, 0, 0, 0, 6'h02, 6'h0d, 5'd4); set_wb(0, 6'h02, 32'hfadecafe); step();
        chk("byp_vld", 64'(o_vld), 64'(1));
        chk("byp_src2", 64'(o_src2_value), 64'hfadecafe);
        i_pu_rdy = 1; step();

        // Full: fifth push dropped, then drain in push order
        for (int k = 0; k < 5; k++) begin
            set_push(1, 32'(k), 0, 1, 32'(k + 100), 0, 6'(6'h10 + k), 5'(k)); step();
        end
        chk("full_after5", 64'(o_full), 64'(1));
        for (int k = 0; k < 4; k++) begin
            chk("drain_dst", 64'(o_dst_phys_rf_tag), 64'(6'h10 + k));
            chk("drain_cnt", 64'(o_count), 64'(4 - k));
            i_pu_rdy = 1; step();
        end
        chk("drain_empty", 64'(o_count), 64'(0));

        // Dual-port wakeup of two entries, then same-tag conflict on both ports
        set_push(0, 0, 6'h03, 1, 32'h7, 0, 6'h21, 5'd5); step();
        set_push(0, 0, 6'h04, 1, 32'h8, 0, 6'h22, 5'd6); step();
        set_wb(0, 6'h03, 32'h11111111); set_wb(1, 6'h04, 32'h22222222); step();
        chk("dual_E", 64'(o_src1_value), 64'h11111111);
        i_pu_rdy = 1; step();
        chk("dual_F", 64'(o_src1_value), 64'h22222222);
        i_pu_rdy = 1; step();
        set_push(0, 0, 6'h03, 1, 32'h9, 0, 6'h23, 5'd7); step();
        set_wb(0, 6'h03, 32'h33333333); set_wb(1, 6'h03, 32'h44444444); step();
        chk("conf_p0", 64'(o_src1_value), 64'h33333333);
        i_pu_rdy = 1; step();

        // Flush with concurrent push and issue
        for (int k = 0; k < 3; k++) begin
            set_push(1, 32'(k), 0, 1, 32'(k), 0, 6'(6'h30 + k), 5'(k)); step();
        end
        set_push(1, 32'h1, 0, 1, 32'h1, 0, 6'h33, 5'd9); i_flush = 1; i_pu_rdy = 1; step();
        chk("flush_empty", 64'(o_empty), 64'(1));
        chk("flush_vld", 64'(o_vld), 64'(0));

        // Reset mid-operation
        for (int k = 0; k < 2; k++) begin
            set_push(1, 32'habc0 + 32'(k), 0, 1, 32'h1234, 0, 6'h3f, 5'h1f); step();
        end
        do_reset();
        chk_reset_vals("rst1");

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 60)
                set_push($urandom_range(0, 1), $urandom, 6'($urandom_range(0, 7)),
                         $urandom_range(0, 1), $urandom, 6'($urandom_range(0, 7)),
                         6'($urandom), 5'($urandom));
            for (int p = 0; p < NW; p++)
                if ($urandom_range(0, 99) < 40) set_wb(p, 6'($urandom_range(0, 7)), $urandom);
            i_pu_rdy = ($urandom_range(0, 99) < 65);
            i_flush  = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 999) < 3) begin
                do_reset();
                chk_reset_vals("rst_rnd");
            end else begin
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rv32i_rs_ooo.md
# rv32i_rs_ooo

Parametrised out-of-order reservation station: it buffers renamed instructions and wakes their source operands from multiple write-back ports. Each cycle it issues the oldest entry whose operands are both valid to its processing unit. It sits between rename/dispatch and one functional unit. It replaces in-order FIFO issue with age-ordered select, and adds multi-port wakeup, flush and occupancy count.

## Interface
- NUM_ENTRIES, default 4: entry count, ≥2.
- NUM_WB, default 2: number of write-back (wakeup) ports, ≥1.
- DATA_BW, default 32: operand width.
- TAG_BW, default 6: physical register tag width.
- ROB_IDX_BW, default 5: ROB index width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_push  in  1  dispatch request; accepted iff !o_full && !i_flush.
- i_src1_value_vld, i_src2_value_vld  in  1  source value already available.
- i_src1_value, i_src2_value  in  DATA_BW  source value, used when vld=1.
- i_src1_phys_rf_tag, i_src2_phys_rf_tag  in  TAG_BW  source tag, used when vld=0.
- i_dst_phys_rf_tag  in  TAG_BW  destination tag, carried through.
- i_rob_entry_idx  in  ROB_IDX_BW  ROB index, carried through.
- i_write_back  in  NUM_WB  per-port write-back valid.
- i_phys_rf_wr_idx  in  NUM_WB*TAG_BW  per-port tag; port p at [p*TAG_BW +: TAG_BW].
- i_wdata  in  NUM_WB*DATA_BW  per-port data, same packing.
- i_flush  in  1  discard all entries.
- i_pu_rdy  in  1  processing unit accepts the issued entry this cycle.
- o_full, o_empty  out  1  occupancy == NUM_ENTRIES / == 0.
- o_count  out  $clog2(NUM_ENTRIES+1)  occupied entries.
- o_vld  out  1  an issuable entry is presented.
- o_src1_value, o_src2_value  out  DATA_BW  operands of the presented entry.
- o_dst_phys_rf_tag  out  TAG_BW; o_rob_entry_idx  out  ROB_IDX_BW  fields of the presented entry.

## Operation
- Storage is a collapsing age queue. Slot 0 is the oldest. Valid slots are always 0..o_count-1.
- Per slot: src1/src2 ready bits, value-or-tag per source, dst tag, ROB index.
- Wakeup, stored entries: for each not-ready source, if any port p has i_write_back[p] and a tag match, capture that port's wdata and set ready. If several ports match, the lowest p wins.
- Wakeup, push bypass: a pushed source with vld=0 and a same-cycle matching write-back is stored ready with that wdata.
- Select: o_vld = 1 iff some valid slot has both sources ready at the start of the cycle. Output fields come from the lowest-index such slot, combinationally from registers. An entry woken this cycle is not issuable until the next cycle.
- Issue fires when o_vld && i_pu_rdy. The selected slot k is removed, and slots k+1..count-1 shift down by one. Wakeups apply to the shifted data in the same cycle.
- Push writes slot (count − issue_fire). Simultaneous push and issue is allowed whenever o_full=0.
- Push while o_full=1 is dropped with no state change. o_full is not relieved by a same-cycle issue.
- Flush: all slots invalid next cycle. Same-cycle push and issue are discarded, and the PU must ignore o_vld in a flush cycle. Wakeups that cycle are ignored.
- rst: all slots invalid, all stored fields zeroed. Reset takes priority over flush, push and issue.
- Reset values: o_vld=0, o_full=0, o_empty=1, o_count=0, and all data, tag and index outputs 0.
- When o_vld=0, the data outputs hold the slot-0 contents, which are don't-care for the PU.

## Timing
- Push with both sources valid in cycle N: o_vld=1 in N+1.
- Write-back in N completing an entry: issuable in N+1.
- Issue in N: entry absent and o_count updated in N+1.
- o_full, o_empty and o_count are registered-state-derived. None has a combinational path from any input.
- o_vld and the data outputs have no combinational dependence on i_push, i_write_back or i_pu_rdy.

## Test plan
- Reset/ordering: push A (srcs 0xbbbbaaaa, 0xcacacaca, dst 0x0c) with i_pu_rdy=1 → o_vld in the next cycle with those values. o_count returns to 0.
- Out-of-order issue: push B (both tags 0x00, dst 0x0a), then C (ready, dst 0x0b) → C issues first. Then WB port 1 with tag 0x00 and data 0xdaddad00 → B issues next cycle, both operands 0xdaddad00.
- Push bypass: push src2 tag 0x02 together with WB port 0 tag 0x02, data 0xfadecafe → entry issues next cycle with src2=0xfadecafe.
- Full/backpressure: i_pu_rdy=0, push 5 ready entries → o_full after 4, the 5th is dropped. Release i_pu_rdy → dst tags issue in push order, o_count goes 4→0.
- Dual-port conflict: two entries waiting on tags 0x03 and 0x04, both ports write back in the same cycle → both captured. Also drive both ports with tag 0x03 → port 0 data is taken.
- Flush and reset: with 3 entries resident, assert i_flush together with a push → o_empty=1 next cycle and no issue. Assert rst mid-operation → all outputs read their reset values next cycle.
